// File: rtl/n1_pagu_seq.sv
// Program address generation unit sequencer.
// It computes the next fetch or data address and runs one pipelined
// program-bus access for each accepted request.
module n1_pagu_seq #(
  parameter int unsigned          ADR_WIDTH        = 16,
  parameter logic [ADR_WIDTH-1:0] PBUS_AADR_OFFSET = '0,
  parameter logic [ADR_WIDTH-1:0] PBUS_MADR_OFFSET = '0,
  parameter logic [ADR_WIDTH-1:0] RESET_ADR        = '0
) (
  input  logic                 clk_i,
  input  logic                 async_rst_i,
  input  logic                 sync_rst_i,

  input  logic                 fc2pagu_next_i,

  input  logic                 ir2pagu_jmp_or_cal_i,
  input  logic                 ir2pagu_cal_i,
  input  logic                 ir2pagu_bra_i,
  input  logic                 ir2pagu_bra_taken_i,
  input  logic                 ir2pagu_mem_i,
  input  logic                 ir2pagu_aadr_sel_i,
  input  logic                 ir2pagu_madr_sel_i,
  input  logic [13:0]          ir2pagu_aadr_i,
  input  logic [12:0]          ir2pagu_radr_i,
  input  logic [7:0]           ir2pagu_madr_i,

  input  logic [ADR_WIDTH-1:0] prs2pagu_ps0_i,

  output logic                 pbus_cyc_o,
  output logic                 pbus_stb_o,
  output logic                 pbus_tga_dat_o,
  output logic [ADR_WIDTH-1:0] pbus_adr_o,
  input  logic                 pbus_stall_i,
  input  logic                 pbus_ack_i,

  output logic                 pagu2fc_busy_o,
  output logic [ADR_WIDTH-1:0] pagu_pc_o,
  output logic [ADR_WIDTH-1:0] pagu2prs_ret_o
);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StIdle = 2'd1;
  localparam logic [1:0] StReq  = 2'd2;
  localparam logic [1:0] StWait = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [ADR_WIDTH-1:0] pc_q, pc_d;
  logic [ADR_WIDTH-1:0] ret_q, ret_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic                 tga_q, tga_d;

  logic [ADR_WIDTH-1:0] pc_inc;
  logic [ADR_WIDTH-1:0] mem_adr;
  logic [ADR_WIDTH-1:0] target;

  assign pc_inc = pc_q + ADR_WIDTH'(1);

  // Address candidates; priority is jump/call > taken branch > sequential.
  always_comb begin
    mem_adr = ir2pagu_madr_sel_i ? prs2pagu_ps0_i
                                 : ADR_WIDTH'(ir2pagu_madr_i) + PBUS_MADR_OFFSET;
    if (ir2pagu_jmp_or_cal_i) begin
      target = ir2pagu_aadr_sel_i ? prs2pagu_ps0_i
                                  : ADR_WIDTH'(ir2pagu_aadr_i) + PBUS_AADR_OFFSET;
    end else if (ir2pagu_bra_i && ir2pagu_bra_taken_i) begin
      target = pc_q + ADR_WIDTH'($signed(ir2pagu_radr_i));
    end else begin
      target = pc_inc;
    end
  end

  // Sequencer next state; synchronous reset overrides every other input.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    adr_d   = adr_q;
    tga_d   = tga_q;
    if (sync_rst_i) begin
      state_d = StBoot;
      pc_d    = RESET_ADR;
      ret_d   = '0;
      adr_d   = '0;
      tga_d   = 1'b0;
    end else begin
      case (state_q)
        StBoot: begin
          state_d = StReq;
          pc_d    = RESET_ADR;
          adr_d   = RESET_ADR;
          tga_d   = 1'b0;
        end
        StIdle: begin
          if (fc2pagu_next_i) begin
            state_d = StReq;
            if (ir2pagu_mem_i) begin
              // Data access leaves the PC pointing at the current instruction.
              adr_d = mem_adr;
              tga_d = 1'b1;
            end else begin
              pc_d  = target;
              adr_d = target;
              tga_d = 1'b0;
              if (ir2pagu_jmp_or_cal_i && ir2pagu_cal_i) begin
                ret_d = pc_inc;
              end
            end
          end
        end
        StReq: begin
          if (!pbus_stall_i) begin
            state_d = pbus_ack_i ? StIdle : StWait;
          end
        end
        StWait: begin
          if (pbus_ack_i) begin
            state_d = StIdle;
          end
        end
        default: state_d = StBoot;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= StBoot;
      pc_q    <= RESET_ADR;
      ret_q   <= '0;
      adr_q   <= '0;
      tga_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      adr_q   <= adr_d;
      tga_q   <= tga_d;
    end
  end

  // Bus strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    pbus_cyc_o     = (state_q == StReq) || (state_q == StWait);
    pbus_stb_o     = (state_q == StReq);
    pbus_tga_dat_o = tga_q;
    pbus_adr_o     = adr_q;
    pagu2fc_busy_o = (state_q != StIdle);
    pagu_pc_o      = pc_q;
    pagu2prs_ret_o = ret_q;
  end

endmodule

// File: tb/tb_n1_pagu_seq.sv
// Randomized bench for n1_pagu_seq against an arithmetic reference model.
module tb_n1_pagu_seq;

  localparam int unsigned AW    = 16;
  localparam logic [15:0] RST_A = 16'h0100;
  localparam logic [15:0] AOFF  = 16'h8000;
  localparam logic [15:0] MOFF  = 16'hFF00;

  logic        clk = 1'b0;
  logic        arst_n, srst, next;
  logic        jc, cal, bra, taken, mem, asel, msel;
  logic [13:0] aadr;
  logic [12:0] radr;
  logic [7:0]  madr;
  logic [15:0] ps0;
  logic        stall, ack;
  logic        cyc, stb, tga, busy;
  logic [15:0] adr, pc, ret;

  int n_vec = 0;
  int n_err = 0;
  int m_pc, m_ret;

  n1_pagu_seq #(
    .ADR_WIDTH       (AW),
    .PBUS_AADR_OFFSET(AOFF),
    .PBUS_MADR_OFFSET(MOFF),
    .RESET_ADR       (RST_A)
  ) dut (
    .clk_i               (clk),
    .async_rst_i         (arst_n),
    .sync_rst_i          (srst),
    .fc2pagu_next_i      (next),
    .ir2pagu_jmp_or_cal_i(jc),
    .ir2pagu_cal_i       (cal),
    .ir2pagu_bra_i       (bra),
    .ir2pagu_bra_taken_i (taken),
    .ir2pagu_mem_i       (mem),
    .ir2pagu_aadr_sel_i  (asel),
    .ir2pagu_madr_sel_i  (msel),
    .ir2pagu_aadr_i      (aadr),
    .ir2pagu_radr_i      (radr),
    .ir2pagu_madr_i      (madr),
    .prs2pagu_ps0_i      (ps0),
    .pbus_cyc_o          (cyc),
    .pbus_stb_o          (stb),
    .pbus_tga_dat_o      (tga),
    .pbus_adr_o          (adr),
    .pbus_stall_i        (stall),
    .pbus_ack_i          (ack),
    .pagu2fc_busy_o      (busy),
    .pagu_pc_o           (pc),
    .pagu2prs_ret_o      (ret)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr_ctl();
    jc = 0; cal = 0; bra = 0; taken = 0; mem = 0; asel = 0; msel = 0;
    aadr = '0; radr = '0; madr = '0; ps0 = '0;
  endtask

  task automatic rand_ctl();
    jc    = ($urandom % 3) == 0;
    cal   = 1'($urandom);
    bra   = 1'($urandom);
    taken = 1'($urandom);
    mem   = ($urandom % 5) == 0;
    asel  = 1'($urandom);
    msel  = 1'($urandom);
    aadr  = 14'($urandom);
    radr  = 13'($urandom);
    madr  = 8'($urandom);
    ps0   = 16'($urandom);
  endtask

  // Reference: next bus address from the decoded controls, with plain integer arithmetic.
  task automatic ref_next(output int e_adr, output bit e_tga);
    int t;
    int r;
    if (mem) begin
      e_tga = 1;
      e_adr = msel ? int'(ps0) : (int'(madr) + int'(MOFF)) % 65536;
    end else begin
      e_tga = 0;
      if (jc) begin
        t = asel ? int'(ps0) : (int'(aadr) + int'(AOFF)) % 65536;
        if (cal) m_ret = (m_pc + 1) % 65536;
      end else if (bra && taken) begin
        r = int'(radr);
        if (r >= 4096) r = r - 8192;
        t = (m_pc + r + 65536) % 65536;
      end else begin
        t = (m_pc + 1) % 65536;
      end
      m_pc  = t;
      e_adr = t;
    end
  endtask

  // Runs the bus side of an access already in REQ: stalls, then ack now or later.
  task automatic bus_finish(input int e_adr, input int nstall);
    bit a;
    int w;
    for (int i = 0; i < nstall; i++) begin
      stall = 1;
      next  = 1'($urandom);
      rand_ctl();
      @(negedge clk);
      check_eq("stall_stb", stb, 1);
      check_eq("stall_adr", adr, e_adr);
      check_eq("stall_pc", pc, m_pc);
    end
    next  = 0;
    stall = 0;
    a     = 1'($urandom);
    ack   = a;
    @(negedge clk);
    if (!a) begin
      check_eq("wait_cyc", cyc, 1);
      check_eq("wait_stb", stb, 0);
      w = $urandom_range(0, 2);
      for (int i = 0; i < w; i++) begin
        @(negedge clk);
        check_eq("wait_hold", {cyc, stb}, 2'b10);
      end
      ack = 1;
      @(negedge clk);
    end
    ack = 0;
    check_eq("done_busy", busy, 0);
    check_eq("done_cyc", cyc, 0);
  endtask

  task automatic do_next(input int nstall);
    int e_adr;
    bit e_tga;
    check_eq("idle_busy", busy, 0);
    if (($urandom % 4) == 0) begin
      ack = 1;
      @(negedge clk);
      ack = 0;
      check_eq("idle_ack", busy, 0);
    end
    ref_next(e_adr, e_tga);
    next = 1;
    @(negedge clk);
    next = 0;
    check_eq("acc_stb", stb, 1);
    check_eq("acc_adr", adr, e_adr);
    check_eq("acc_tga", tga, e_tga);
    check_eq("acc_pc", pc, m_pc);
    check_eq("acc_ret", ret, m_ret);
    bus_finish(e_adr, nstall);
  endtask

  task automatic jump_to(input logic [15:0] a);
    clr_ctl();
    jc = 1; asel = 1; ps0 = a;
    do_next(0);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_busy"}, busy, 1);
    check_eq({tag, "_cs"}, {cyc, stb, tga}, 3'b000);
    check_eq({tag, "_adr"}, adr, 0);
    check_eq({tag, "_pc"}, pc, RST_A);
    check_eq({tag, "_ret"}, ret, 0);
  endtask

  // Entered at a negedge with reset just released and the DUT in BOOT.
  task automatic boot_seq();
    m_pc  = RST_A;
    m_ret = 0;
    check_eq("boot_busy", busy, 1);
    check_eq("boot_stb", stb, 0);
    @(negedge clk);
    check_eq("boot_stb1", stb, 1);
    check_eq("boot_adr", adr, RST_A);
    check_eq("boot_tga", tga, 0);
    check_eq("boot_pc", pc, RST_A);
    bus_finish(RST_A, $urandom_range(0, 1));
  endtask

  initial begin
    int e_adr;
    bit e_tga;
    arst_n = 0; srst = 0; next = 0; stall = 0; ack = 0;
    clr_ctl();
    repeat (3) @(negedge clk);
    check_reset("arst");
    arst_n = 1;
    boot_seq();

    // Branch taken backwards by two, then not taken.
    jump_to(16'h0010);
    clr_ctl(); bra = 1; taken = 1; radr = 13'h1FFE;
    do_next(0);
    check_eq("bra_taken", pc, 16'h000E);
    jump_to(16'h0010);
    clr_ctl(); bra = 1; taken = 0; radr = 13'h1FFE;
    do_next(1);
    check_eq("bra_not", pc, 16'h0011);

    // Call with offset absolute address.
    jump_to(16'h0020);
    clr_ctl(); jc = 1; cal = 1; aadr = 14'h0400;
    do_next(0);
    check_eq("cal_pc", pc, 16'h8400);
    check_eq("cal_ret", ret, 16'h0021);

    // Data access leaves PC alone.
    jump_to(16'h0030);
    clr_ctl(); mem = 1; madr = 8'h12;
    ref_next(e_adr, e_tga);
    next = 1;
    @(negedge clk);
    next = 0;
    check_eq("mem_adr", adr, 16'hFF12);
    check_eq("mem_tga", tga, 1);
    check_eq("mem_pc", pc, 16'h0030);
    bus_finish(e_adr, 0);

    // Wrap from all-ones with three stalled cycles.
    jump_to(16'hFFFF);
    clr_ctl();
    do_next(3);
    check_eq("wrap_pc", pc, 16'h0000);

    for (int i = 0; i < 150; i++) begin
      rand_ctl();
      do_next($urandom_range(0, 3));
    end

    // Sync reset beats a simultaneous next in IDLE.
    rand_ctl();
    next = 1; srst = 1;
    @(negedge clk);
    next = 0; srst = 0;
    check_reset("srst_idle");
    boot_seq();

    // Sync reset during a stalled REQ with ack high abandons the access.
    rand_ctl();
    ref_next(e_adr, e_tga);
    next = 1;
    @(negedge clk);
    next = 0; stall = 1; ack = 1; srst = 1;
    @(negedge clk);
    srst = 0; stall = 0; ack = 0;
    check_reset("srst_req");
    boot_seq();

    // Async reset during WAIT drops the cycle without waiting for a clock.
    rand_ctl();
    ref_next(e_adr, e_tga);
    next = 1;
    @(negedge clk);
    next = 0; stall = 0; ack = 0;
    @(negedge clk);
    check_eq("pre_arst", {cyc, stb}, 2'b10);
    #2 arst_n = 0;
    #1 check_reset("arst_wait");
    @(negedge clk);
    arst_n = 1;
    boot_seq();
    rand_ctl();
    do_next(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
